// File: rtl/ram_ctrl.sv
// RAM access sequencer for a 4-bit x 4K RAM: holds the SRC/DCL pointer, issues
// single-cycle reads/writes and returns read data or ADM/SBM results over valid/ready.
module ram_ctrl #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [3:0]        cmdOp,
  input  logic [7:0]        cmdData,
  input  logic [3:0]        accIn,
  input  logic              carryIn,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [3:0]        rspData,
  output logic              rspCarry,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic              ramRe,
  output logic [3:0]        ramWData,
  input  logic [3:0]        ramRData
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t             state_r;
  logic [7:0]         ptr_r;
  logic [BANK_W-1:0]  bank_r;
  logic [3:0]         acc_r;
  logic               carry_r;
  logic [3:0]         op_r;
  logic [ADDR_W-1:0]  addr_s;
  logic [1:0]         n_s;
  logic [4:0]         result_s;

  // Address for the op being presented, built from the pointer/bank held at accept.
  // Status index is op-6 for WRn and op-10 for RDn; both reduce to op[1:0]+2.
  always_comb begin
    n_s = cmdOp[1:0] + 2'd2;
    if ((cmdOp >= 4'd6) && (cmdOp <= 4'd13)) begin
      addr_s = {1'b1, 2'b00, bank_r, ptr_r[7:4], n_s};
    end else begin
      addr_s = {1'b0, bank_r, ptr_r};
    end
  end

  // Read-cycle result: plain data, ADM sum, or SBM sum with inverted operand/borrow.
  always_comb begin
    case (op_r)
      4'd4:    result_s = {1'b0, acc_r} + {1'b0, ramRData} + {4'b0000, carry_r};
      4'd5:    result_s = {1'b0, acc_r} + {1'b0, ~ramRData} + {4'b0000, ~carry_r};
      default: result_s = {1'b0, ramRData};
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= 8'h00;
      bank_r   <= '0;
      acc_r    <= 4'h0;
      carry_r  <= 1'b0;
      op_r     <= 4'h0;
      cmdReady <= 1'b1;
      rspValid <= 1'b0;
      rspData  <= 4'h0;
      rspCarry <= 1'b0;
      ramAddr  <= '0;
      ramWe    <= 1'b0;
      ramRe    <= 1'b0;
      ramWData <= 4'h0;
    end else begin
      ramWe <= 1'b0;
      ramRe <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmdValid) begin
            case (cmdOp)
              4'd0: ptr_r  <= cmdData;
              4'd1: bank_r <= cmdData[BANK_W-1:0];
              4'd2, 4'd6, 4'd7, 4'd8, 4'd9: begin
                ramAddr  <= addr_s;
                ramWData <= accIn;
                ramWe    <= 1'b1;
                cmdReady <= 1'b0;
                state_r  <= WRITE;
              end
              4'd3, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13: begin
                ramAddr  <= addr_s;
                ramRe    <= 1'b1;
                acc_r    <= accIn;
                carry_r  <= carryIn;
                op_r     <= cmdOp;
                cmdReady <= 1'b0;
                state_r  <= READ;
              end
              default: ;
            endcase
          end
        end
        WRITE: begin
          cmdReady <= 1'b1;
          state_r  <= IDLE;
        end
        READ: begin
          rspData  <= result_s[3:0];
          rspCarry <= result_s[4];
          rspValid <= 1'b1;
          state_r  <= RESP;
        end
        RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            cmdReady <= 1'b1;
            state_r  <= IDLE;
          end
        end
        default: begin
          cmdReady <= 1'b1;
          rspValid <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural 4-bit x 4K RAM attached.
module tb_ram_ctrl;
  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [3:0]  cmdOp;
  logic [7:0]  cmdData;
  logic [3:0]  accIn;
  logic        carryIn;
  logic        rspValid;
  logic        rspReady;
  logic [3:0]  rspData;
  logic        rspCarry;
  logic [11:0] ramAddr;
  logic        ramWe;
  logic        ramRe;
  logic [3:0]  ramWData;
  logic [3:0]  ramRData;

  logic [3:0]  mem [4096];
  int          checks;
  int          failures;
  int          we_cnt;
  int          both_cnt;
  int          we0;

  ram_ctrl dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdData(cmdData),
    .accIn(accIn), .carryIn(carryIn),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspCarry(rspCarry),
    .ramAddr(ramAddr), .ramWe(ramWe), .ramRe(ramRe), .ramWData(ramWData),
    .ramRData(ramRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWData;
  end
  assign ramRData = ramRe ? mem[ramAddr] : 4'h0;

  always @(negedge clk) begin
    if (ramWe) we_cnt <= we_cnt + 1;
    if (ramWe && ramRe) both_cnt <= both_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one command for a single edge; caller guarantees the DUT is idle.
  task automatic send(input logic [3:0] op, input logic [7:0] data, input logic [3:0] acc,
                      input logic cin);
    cmdOp = op; cmdData = data; accIn = acc; carryIn = cin; cmdValid = 1'b1;
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic take_rsp(input string tag);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    check_val({tag, "_rspv_low"}, 16'(rspValid), 16'h0000);
    check_val({tag, "_rdy_back"}, 16'(cmdReady), 16'h0001);
  endtask

  initial begin
    checks = 0; failures = 0; we_cnt = 0; both_cnt = 0;
    rst = 1'b1; cmdValid = 1'b0; cmdOp = 4'h0; cmdData = 8'h00;
    accIn = 4'h0; carryIn = 1'b0; rspReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready", 16'(cmdReady), 16'h0001);
    check_val("rst_rspv",  16'(rspValid), 16'h0000);
    check_val("rst_addr",  16'(ramAddr),  16'h0000);
    check_val("rst_we_re", 16'({ramWe, ramRe}), 16'h0000);
    rst = 1'b0;
    step();

    // 1: reset during READ aborts the response
    send(4'd2, 8'h00, 4'h7, 1'b0);
    step();
    send(4'd1, 8'h05, 4'h0, 1'b0);
    send(4'd0, 8'h9A, 4'h0, 1'b0);
    send(4'd3, 8'h00, 4'h0, 1'b0);
    check_val("t1_in_read", 16'(ramRe), 16'h0001);
    rst = 1'b1;
    #1;
    check_val("t1_rst_rspv", 16'(rspValid), 16'h0000);
    check_val("t1_rst_re",   16'(ramRe),    16'h0000);
    check_val("t1_rst_rdy",  16'(cmdReady), 16'h0001);
    rst = 1'b0;
    step();
    step();
    check_val("t1_after_rspv", 16'(rspValid), 16'h0000);
    send(4'd3, 8'h00, 4'h0, 1'b0);
    check_val("t1_rd_addr", 16'(ramAddr), 16'h0000);
    check_val("t1_rd_re",   16'(ramRe),   16'h0001);
    step();
    check_val("t1_rspv", 16'(rspValid), 16'h0001);
    check_val("t1_data", 16'(rspData),  16'h0007);
    check_val("t1_cy",   16'(rspCarry), 16'h0000);
    take_rsp("t1");

    // 2: DCL 5, SRC 0x9A, WRM
    send(4'd1, 8'h05, 4'h0, 1'b0);
    send(4'd0, 8'h9A, 4'h0, 1'b0);
    we0 = we_cnt;
    send(4'd2, 8'h00, 4'hC, 1'b0);
    check_val("t2_we",    16'(ramWe),    16'h0001);
    check_val("t2_re",    16'(ramRe),    16'h0000);
    check_val("t2_addr",  16'(ramAddr),  16'h059A);
    check_val("t2_wdata", 16'(ramWData), 16'h000C);
    check_val("t2_rdy",   16'(cmdReady), 16'h0000);
    step();
    check_val("t2_we_end", 16'(ramWe),     16'h0000);
    check_val("t2_rdy_end",16'(cmdReady),  16'h0001);
    check_val("t2_pulses", 16'(we_cnt - we0), 16'h0001);

    // 3: status char 2 write then read: {1,00,101,10,01,10}
    send(4'd8, 8'h00, 4'h3, 1'b0);
    check_val("t3_wr_addr", 16'(ramAddr), 16'h0966);
    check_val("t3_wr_we",   16'(ramWe),   16'h0001);
    step();
    send(4'd12, 8'h00, 4'h0, 1'b0);
    check_val("t3_rd_addr", 16'(ramAddr), 16'h0966);
    check_val("t3_rd_re",   16'(ramRe),   16'h0001);
    step();
    check_val("t3_rspv", 16'(rspValid), 16'h0001);
    check_val("t3_data", 16'(rspData),  16'h0003);
    check_val("t3_cy",   16'(rspCarry), 16'h0000);
    take_rsp("t3");

    // 4: ADM 8+9+1 = 0x12, SBM 3+~5+~0 = 0x0E
    send(4'd2, 8'h00, 4'h9, 1'b0);
    step();
    send(4'd4, 8'h00, 4'h8, 1'b1);
    step();
    check_val("t4_adm_data", 16'(rspData),  16'h0002);
    check_val("t4_adm_cy",   16'(rspCarry), 16'h0001);
    take_rsp("t4a");
    send(4'd2, 8'h00, 4'h5, 1'b0);
    step();
    send(4'd5, 8'h00, 4'h3, 1'b0);
    step();
    check_val("t4_sbm_data", 16'(rspData),  16'h000E);
    check_val("t4_sbm_cy",   16'(rspCarry), 16'h0000);
    take_rsp("t4s");

    // 5: stalled response with a pending WRM
    send(4'd3, 8'h00, 4'h0, 1'b0);
    step();
    cmdOp = 4'd2; accIn = 4'h6; cmdValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("t5_rspv",  16'(rspValid), 16'h0001);
      check_val("t5_data",  16'(rspData),  16'h0005);
      check_val("t5_rdy",   16'(cmdReady), 16'h0000);
      check_val("t5_no_we", 16'(ramWe),    16'h0000);
      step();
    end
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    check_val("t5_rsp_done", 16'(rspValid), 16'h0000);
    check_val("t5_rdy_back", 16'(cmdReady), 16'h0001);
    check_val("t5_not_yet",  16'(ramWe),    16'h0000);
    step();
    cmdValid = 1'b0;
    check_val("t5_wr_we",   16'(ramWe),    16'h0001);
    check_val("t5_wr_data", 16'(ramWData), 16'h0006);
    step();

    // 6: three back-to-back WRMs with cmdValid held
    we0 = we_cnt;
    both_cnt = 0;
    cmdOp = 4'd2; accIn = 4'hA; cmdValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic exp_we;
      step();
      exp_we = ((i % 2) == 0);
      check_val("t6_we_pattern", 16'(ramWe), 16'(exp_we));
      if (i == 4) cmdValid = 1'b0;
    end
    step();
    check_val("t6_pulses", 16'(we_cnt - we0), 16'h0003);
    check_val("t6_we_re",  16'(both_cnt),     16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
